// File: rtl/mem_copy_engine.sv
// Bulk-transfer helper on the data-memory port: block copy (src->dst) or
// block fill (constant->dst) of word-addressed memory, one word per WRITE.
module mem_copy_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic              memWrite,
    output logic              memRead,
    input  logic [DATA_W-1:0] readData,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_nxt;

    assign idx_nxt = idx + LEN_W'(1);

    // Write data is a mux of registers only, gated by the registered write enable,
    // so it is settled well before the memory commits on the negedge.
    assign writeData = memWrite ? (mode_q ? fill_q : data_q) : '0;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            data_q     <= '0;
            idx        <= '0;
            address    <= '0;
            memWrite   <= 1'b0;
            memRead    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q     <= mode;
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        len_q      <= length;
                        fill_q     <= fill_value;
                        idx        <= '0;
                        words_done <= '0;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state    <= WRITE;
                            address  <= dst_addr;
                            memWrite <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state   <= READ;
                            address <= src_addr;
                            memRead <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    data_q   <= readData;
                    state    <= WRITE;
                    address  <= dst_q + ADDR_W'(idx);
                    memRead  <= 1'b0;
                    memWrite <= 1'b1;
                end
                WRITE: begin
                    idx        <= idx_nxt;
                    words_done <= idx_nxt;
                    if (idx_nxt == len_q) begin
                        state    <= DONE;
                        address  <= '0;
                        memWrite <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else if (mode_q) begin
                        address <= dst_q + ADDR_W'(idx_nxt);
                    end else begin
                        // copy alternates: fetch the next source word before writing it
                        state    <= READ;
                        address  <= src_q + ADDR_W'(idx_nxt);
                        memWrite <= 1'b0;
                        memRead  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    address  <= '0;
                    memWrite <= 1'b0;
                    memRead  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: vector table for whole commands plus
// hand sequences for reset behaviour and mid-transfer abort.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [5:0]  length = '0;
    logic [31:0] fill_value = '0;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;
    logic        busy;
    logic        done;
    logic [5:0]  words_done;

    logic [31:0] mem [64];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_copy_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(6)) dut (
        .clock_in(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_value(fill_value), .address(address), .writeData(writeData),
        .memWrite(memWrite), .memRead(memRead), .readData(readData),
        .busy(busy), .done(done), .words_done(words_done)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, write on negedge, 64 words (address mod 64).
    assign readData = mem[address[5:0]];
    always @(negedge clk) begin
        if (memWrite) begin
            mem[address[5:0]] = writeData;
            wr_cnt++;
        end
        if (memRead) rd_cnt++;
    end

    typedef struct packed {
        logic           mode;
        logic [31:0]    src;
        logic [31:0]    dst;
        logic [5:0]     len;
        logic [31:0]    fill;
        int             lat;
        int             writes;
        int             reads;
        int             chk_base;
        int             chk_n;
        logic [4:0][31:0] chk;
    } vec_t;

    function automatic vec_t mk(logic m, logic [31:0] s, logic [31:0] d, logic [5:0] l,
                                logic [31:0] f, int lat, int wr, int rd, int base, int n,
                                logic [31:0] c0, logic [31:0] c1, logic [31:0] c2,
                                logic [31:0] c3, logic [31:0] c4);
        vec_t t;
        t.mode = m; t.src = s; t.dst = d; t.len = l; t.fill = f;
        t.lat = lat; t.writes = wr; t.reads = rd; t.chk_base = base; t.chk_n = n;
        t.chk[0] = c0; t.chk[1] = c1; t.chk[2] = c2; t.chk[3] = c3; t.chk[4] = c4;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++) mem[i] = i;
    endtask

    vec_t tv [6];

    initial begin
        tv[0] = mk(1'b0, 32'd2, 32'd20, 6'd4, 32'h0, 9, 4, 4, 20, 5,
                   32'd2, 32'd3, 32'd4, 32'd5, 32'd24);
        tv[1] = mk(1'b1, 32'd0, 32'd8, 6'd3, 32'hDEADBEEF, 4, 3, 0, 8, 4,
                   32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hB, 32'h0);
        tv[2] = mk(1'b0, 32'd5, 32'd12, 6'd0, 32'h0, 1, 0, 0, 11, 3,
                   32'd11, 32'd12, 32'd13, 32'h0, 32'h0);
        tv[3] = mk(1'b0, 32'd0, 32'd1, 6'd3, 32'h0, 7, 3, 3, 1, 4,
                   32'd0, 32'd0, 32'd0, 32'd4, 32'h0);
        tv[4] = mk(1'b1, 32'd0, 32'hFFFFFFFE, 6'd3, 32'h55, 4, 3, 0, 62, 4,
                   32'h55, 32'h55, 32'h55, 32'd1, 32'h0);
        tv[5] = mk(1'b1, 32'd0, 32'd0, 6'd63, 32'h7, 64, 63, 0, 61, 3,
                   32'h7, 32'h7, 32'd63, 32'h0, 32'h0);

        preload();
        // reset held for two edges, then released
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_address", address, 0);
        check("rst_memWrite", memWrite, 0);
        check("rst_memRead", memRead, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words_done", words_done, 0);

        for (int v = 0; v < 6; v++) begin
            int k;
            preload();
            mode = tv[v].mode; src_addr = tv[v].src; dst_addr = tv[v].dst;
            length = tv[v].len; fill_value = tv[v].fill; start = 1'b1;
            tick();
            wr_cnt = 0;
            rd_cnt = 0;
            // command inputs are free to change once accepted
            start = 1'b0;
            mode = $urandom; src_addr = $urandom; dst_addr = $urandom;
            length = $urandom; fill_value = $urandom;
            check($sformatf("v%0d_busy_first", v), busy, (tv[v].len != 0));
            k = 1;
            while (!done && k < 300) begin
                tick();
                k++;
            end
            check($sformatf("v%0d_done_seen", v), done, 1);
            check($sformatf("v%0d_latency", v), k, tv[v].lat);
            check($sformatf("v%0d_words_done", v), words_done, tv[v].len);
            check($sformatf("v%0d_busy_at_done", v), busy, 0);
            check($sformatf("v%0d_mem_outs_at_done", v),
                  {address, writeData, memWrite, memRead}, 0);
            tick();
            check($sformatf("v%0d_done_pulse", v), done, 0);
            check($sformatf("v%0d_write_cycles", v), wr_cnt, tv[v].writes);
            check($sformatf("v%0d_read_cycles", v), rd_cnt, tv[v].reads);
            for (int c = 0; c < tv[v].chk_n; c++)
                check($sformatf("v%0d_mem[%0d]", v, (tv[v].chk_base + c) % 64),
                      mem[(tv[v].chk_base + c) % 64], tv[v].chk[c]);
        end

        // Copy aborted by reset after its second WRITE; a re-pulsed start is ignored.
        preload();
        mode = 1'b0; src_addr = 32'd0; dst_addr = 32'd16; length = 6'd8; start = 1'b1;
        tick();
        wr_cnt = 0;
        start = 1'b0;
        tick();
        check("abort_in_write", memWrite, 1);
        mode = 1'b1; dst_addr = 32'd40; fill_value = 32'hAAAA5555; length = 6'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy_ignores_start", {busy, memRead, address}, {1'b1, 1'b1, 32'd1});
        tick();
        check("abort_second_write_addr", address, 32'd17);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_outs_after_reset",
              {address, writeData, memWrite, memRead, busy, done, words_done}, 0);
        tick();
        tick();
        check("abort_write_cycles", wr_cnt, 2);
        check("abort_mem16", mem[16], 32'd0);
        check("abort_mem17", mem[17], 32'd1);
        check("abort_mem18", mem[18], 32'h12);
        check("abort_mem40", mem[40], 32'd40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
